// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of an instruction-fetch port and a data port onto one
// registered memory port. Define MEM_ARBITER_TIMEOUT_EN to add a per-transaction wait timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_IReq,
  input  logic [31:0] i_IAddr,
  output logic        o_IAck,
  output logic [31:0] o_IRdData,
  input  logic        i_DReq,
  input  logic        i_DWrEnable,
  input  logic [31:0] i_DAddr,
  input  logic [31:0] i_DWrData,
  output logic        o_DAck,
  output logic [31:0] o_DRdData,
  output logic        o_MemReq,
  output logic        o_MemWrEnable,
  output logic [31:0] o_MemAddr,
  output logic [31:0] o_MemWrData,
  input  logic [31:0] i_MemRdData,
  input  logic        i_MemReady,
  output logic        o_Busy,
  output logic        o_Error,
  output logic [1:0]  o_DbgState
);

  // Handshake: a requester holds its req (and stable address/data) until its ack pulse;
  // the memory holds o_MemReq/address/data until it returns i_MemReady=1 for one sampled cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IBUS = 2'd1,
    ST_DBUS = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_data_q;
  logic        i_cand;
  logic        d_cand;
  logic        grant_d;
  logic        grant_i;
  logic        timeout_hit;
  logic        xfer_done;
  logic [31:0] rd_word;

  // The port being acked this cycle still shows its request; it must not be re-granted.
  assign i_cand  = i_IReq & ~o_IAck;
  assign d_cand  = i_DReq & ~o_DAck;
  assign grant_d = d_cand & (~i_cand | ~last_data_q);
  assign grant_i = i_cand & ~grant_d;

  assign xfer_done  = i_MemReady | timeout_hit;
  assign rd_word    = i_MemReady ? i_MemRdData : 32'h0;
  assign o_Busy     = (state_q != ST_IDLE);
  assign o_DbgState = state_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       error_q;
  assign timeout_hit = (wait_cnt_q == 8'(TIMEOUT));
  assign o_Error     = error_q;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
  assign o_Error        = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q       <= ST_IDLE;
      last_data_q   <= 1'b0;
      o_MemReq      <= 1'b0;
      o_MemWrEnable <= 1'b0;
      o_MemAddr     <= 32'h0;
      o_MemWrData   <= 32'h0;
      o_IAck        <= 1'b0;
      o_DAck        <= 1'b0;
      o_IRdData     <= 32'h0;
      o_DRdData     <= 32'h0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wait_cnt_q    <= 8'h0;
      error_q       <= 1'b0;
`endif
    end else begin
      o_IAck <= 1'b0;
      o_DAck <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
          wait_cnt_q <= 8'h0;
`endif
          if (grant_d) begin
            state_q       <= ST_DBUS;
            last_data_q   <= 1'b1;
            o_MemReq      <= 1'b1;
            o_MemWrEnable <= i_DWrEnable;
            o_MemAddr     <= i_DAddr;
            o_MemWrData   <= i_DWrData;
          end else if (grant_i) begin
            state_q       <= ST_IBUS;
            last_data_q   <= 1'b0;
            o_MemReq      <= 1'b1;
            o_MemWrEnable <= 1'b0;
            o_MemAddr     <= i_IAddr;
          end
        end
        ST_IBUS, ST_DBUS: begin
          if (xfer_done) begin
            state_q       <= ST_IDLE;
            o_MemReq      <= 1'b0;
            o_MemWrEnable <= 1'b0;
            if (state_q == ST_IBUS) begin
              o_IAck    <= 1'b1;
              o_IRdData <= rd_word;
            end else begin
              o_DAck <= 1'b1;
              if (!o_MemWrEnable) begin
                o_DRdData <= rd_word;
              end
            end
`ifdef MEM_ARBITER_TIMEOUT_EN
            error_q <= ~i_MemReady;
`endif
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model compared every cycle,
// plus literal expectations for the headline scenarios (timeout scenarios need MEM_ARBITER_TIMEOUT_EN).
module tb_mem_arbiter;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TO    = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TO    = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ireq = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic        dreq = 1'b0;
  logic        dwe = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dwdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        o_IAck, o_DAck, o_MemReq, o_MemWrEnable, o_Busy, o_Error;
  logic [31:0] o_IRdData, o_DRdData, o_MemAddr, o_MemWrData;
  logic [1:0]  o_DbgState;

  int    n_checks = 0;
  int    n_errors = 0;
  string ack_log = "";

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .i_Clock(clk), .i_Reset(rst_n),
    .i_IReq(ireq), .i_IAddr(iaddr), .o_IAck(o_IAck), .o_IRdData(o_IRdData),
    .i_DReq(dreq), .i_DWrEnable(dwe), .i_DAddr(daddr), .i_DWrData(dwdata),
    .o_DAck(o_DAck), .o_DRdData(o_DRdData),
    .o_MemReq(o_MemReq), .o_MemWrEnable(o_MemWrEnable), .o_MemAddr(o_MemAddr),
    .o_MemWrData(o_MemWrData), .i_MemRdData(mem_rdata), .i_MemReady(mem_ready),
    .o_Busy(o_Busy), .o_Error(o_Error), .o_DbgState(o_DbgState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory responder: raises ready once o_MemReq has been seen for more than ready_delay cycles.
  int ready_delay = 1;
  int resp_cnt    = 0;
  bit idle_ready  = 1'b0;
  always @(negedge clk) begin
    if (o_MemReq) begin
      resp_cnt++;
      if (resp_cnt > ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = mem_word(o_MemAddr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_0000 + 32'(resp_cnt);
      end
    end else begin
      resp_cnt  = 0;
      mem_ready = idle_ready;
      mem_rdata = 32'hC0DE_0000;
    end
  end

  always @(negedge clk) begin
    if (o_DAck) ack_log = {ack_log, "D"};
    if (o_IAck) ack_log = {ack_log, "I"};
  end

  // Reference model: outstanding transaction (0 none, 1 fetch, 2 data) plus last-grant owner.
  int          m_port = 0;
  int          m_wait = 0;
  logic        m_we = 1'b0, m_last_d = 1'b0;
  logic        m_iack = 1'b0, m_dack = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_irdata = 32'h0, m_drdata = 32'h0;
  logic        n_iack, n_dack, n_err, i_want, d_want;
  logic [31:0] word;

  always @(negedge rst_n) begin
    m_port = 0; m_wait = 0; m_we = 1'b0; m_last_d = 1'b0;
    m_iack = 1'b0; m_dack = 1'b0; m_err = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_irdata = 32'h0; m_drdata = 32'h0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      n_iack = 1'b0; n_dack = 1'b0; n_err = 1'b0;
      if (m_port != 0) begin
        if (mem_ready || (TO_EN && m_wait == TO)) begin
          word  = mem_ready ? mem_rdata : 32'h0;
          n_err = !mem_ready;
          if (m_port == 1) begin
            n_iack = 1'b1; m_irdata = word;
          end else begin
            n_dack = 1'b1;
            if (!m_we) m_drdata = word;
          end
          m_port = 0;
        end else begin
          m_wait++;
        end
      end else begin
        i_want = ireq && !m_iack;
        d_want = dreq && !m_dack;
        if (d_want && (!i_want || !m_last_d)) begin
          m_port = 2; m_we = dwe; m_addr = daddr; m_wdata = dwdata; m_last_d = 1'b1; m_wait = 0;
        end else if (i_want) begin
          m_port = 1; m_we = 1'b0; m_addr = iaddr; m_last_d = 1'b0; m_wait = 0;
        end
      end
      m_iack = n_iack; m_dack = n_dack; m_err = n_err;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mem_req", o_MemReq, m_port != 0);
      chk("busy", o_Busy, m_port != 0);
      chk("dbg_state", o_DbgState, m_port);
      chk("mem_we", o_MemWrEnable, (m_port == 2) && m_we);
      if (m_port != 0) chk("mem_addr", o_MemAddr, m_addr);
      if (m_port == 2 && m_we) chk("mem_wdata", o_MemWrData, m_wdata);
      chk("iack", o_IAck, m_iack);
      chk("dack", o_DAck, m_dack);
      chk("error", o_Error, m_err);
      chk("irdata", o_IRdData, m_irdata);
      chk("drdata", o_DRdData, m_drdata);
      chk("ack_excl", o_IAck & o_DAck, 1'b0);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memreq"}, o_MemReq, 0);
    chk({tag, "_memwe"}, o_MemWrEnable, 0);
    chk({tag, "_memaddr"}, o_MemAddr, 0);
    chk({tag, "_memwdata"}, o_MemWrData, 0);
    chk({tag, "_iack"}, o_IAck, 0);
    chk({tag, "_dack"}, o_DAck, 0);
    chk({tag, "_irdata"}, o_IRdData, 0);
    chk({tag, "_drdata"}, o_DRdData, 0);
    chk({tag, "_busy"}, o_Busy, 0);
    chk({tag, "_error"}, o_Error, 0);
    chk({tag, "_state"}, o_DbgState, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction on one port; lat counts cycles from the first cycle o_MemReq is seen to the ack.
  task automatic run_one(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay,
                         output int lat, output logic err, output logic [31:0] gaddr);
    int k;
    ready_delay = delay;
    @(negedge clk);
    if (is_d) begin
      dreq = 1'b1; dwe = we; daddr = addr; dwdata = wdata;
    end else begin
      ireq = 1'b1; iaddr = addr;
    end
    k = 0;
    @(negedge clk);
    while (!o_MemReq && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", o_MemReq, 1);
    gaddr = o_MemAddr;
    lat = 0;
    while (!(is_d ? o_DAck : o_IAck) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_seen", is_d ? o_DAck : o_IAck, 1);
    err = o_Error;
    if (is_d) dreq = 1'b0;
    else ireq = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int          lat, nacks;
    logic        err;
    logic [31:0] gaddr;
    bit          after_dack;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Fetch only, ready one cycle after o_MemReq.
    run_one(1'b0, 1'b0, 32'h100, 32'h0, 1, lat, err, gaddr);
    chk("fetch_addr", gaddr, 32'h100);
    chk("fetch_latency", lat, 2);
    chk("fetch_data", o_IRdData, 32'h13);

    // Simultaneous fetch and load after reset: data first, one idle cycle, then fetch.
    do_reset();
    @(negedge clk);
    ack_log = ""; ready_delay = 1; after_dack = 1'b0;
    ireq = 1'b1; iaddr = 32'h300; dreq = 1'b1; dwe = 1'b0; daddr = 32'h2000;
    for (int k = 0; k < 40 && (ireq || dreq); k++) begin
      @(negedge clk);
      if (after_dack) begin
        chk("regrant_after_gap", o_MemReq, 1);
        after_dack = 1'b0;
      end
      if (o_DAck) begin
        dreq = 1'b0;
        chk("gap_req_low", o_MemReq, 0);
        after_dack = 1'b1;
      end
      if (o_IAck) ireq = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_str("tie_order", ack_log, "DI");
    chk("tie_load_data", o_DRdData, 32'h5A5A_2000);
    chk("tie_fetch_data", o_IRdData, 32'h5A5A_0300);

    // Store with ready delayed three cycles: four cycles of stable request.
    run_one(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 3, lat, err, gaddr);
    chk("store_addr", gaddr, 32'h40);
    chk("store_latency", lat, 4);
    chk("store_keeps_rdata", o_DRdData, 32'h5A5A_2000);

    // Request held through its own ack cycle must not start a second transaction.
    @(negedge clk);
    ack_log = ""; ready_delay = 1;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h800;
    for (int k = 0; k < 40 && !o_DAck; k++) @(negedge clk);
    @(negedge clk);
    dreq = 1'b0;
    repeat (4) @(negedge clk);
    chk_str("ack_mask", ack_log, "D");
    chk("mask_load_data", o_DRdData, 32'h5A5A_0800);

    // Requester drops its request right after the grant; the access still completes.
    @(negedge clk);
    ready_delay = 2;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h600;
    @(negedge clk);
    dreq = 1'b0;
    for (int k = 0; k < 40 && !o_DAck; k++) @(negedge clk);
    chk("early_drop_ack", o_DAck, 1);
    chk("early_drop_data", o_DRdData, 32'h5A5A_0600);

    // Ready while idle is ignored.
    @(negedge clk);
    ack_log = ""; idle_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_ready_busy", o_Busy, 0);
    idle_ready = 1'b0;
    @(negedge clk);
    chk_str("idle_ready_no_ack", ack_log, "");

    // Both requests held continuously after reset: strict alternation starting with data.
    do_reset();
    @(negedge clk);
    ack_log = ""; ready_delay = 0; nacks = 0;
    ireq = 1'b1; iaddr = 32'h180; dreq = 1'b1; dwe = 1'b0; daddr = 32'h80;
    for (int k = 0; k < 100 && nacks < 6; k++) begin
      @(negedge clk);
      if (o_IAck || o_DAck) nacks++;
      if (nacks == 6) begin
        ireq = 1'b0; dreq = 1'b0;
      end
    end
    ireq = 1'b0; dreq = 1'b0;
    repeat (3) @(negedge clk);
    chk_str("rr_order", ack_log, "DIDIDI");

    // Reset during a data wait abandons it without an ack.
    @(negedge clk);
    ack_log = ""; ready_delay = 100000;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h700;
    for (int k = 0; k < 20 && !o_MemReq; k++) @(negedge clk);
    chk("wait_granted", o_MemReq, 1);
`ifndef MEM_ARBITER_TIMEOUT_EN
    repeat (30) @(negedge clk);
    chk("no_timeout_busy", o_Busy, 1);
    chk("no_timeout_req", o_MemReq, 1);
`else
    repeat (2) @(negedge clk);
`endif
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    dreq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk_str("midreset_no_ack", ack_log, "");
    chk("midreset_idle", o_Busy, 0);

`ifdef MEM_ARBITER_TIMEOUT_EN
    run_one(1'b1, 1'b0, 32'hA00, 32'h0, 1, lat, err, gaddr);
    chk("to_pre_load", o_DRdData, 32'h5A5A_0A00);
    chk("to_pre_err", err, 0);
    run_one(1'b1, 1'b0, 32'h900, 32'h0, 100000, lat, err, gaddr);
    chk("to_latency", lat, 5);
    chk("to_error", err, 1);
    chk("to_rdata_zero", o_DRdData, 32'h0);
    run_one(1'b1, 1'b0, 32'hB00, 32'h0, 4, lat, err, gaddr);
    chk("to_edge_latency", lat, 5);
    chk("to_edge_error", err, 0);
    chk("to_edge_data", o_DRdData, 32'h5A5A_0B00);
    run_one(1'b0, 1'b0, 32'hC00, 32'h0, 100000, lat, err, gaddr);
    chk("to_fetch_error", err, 1);
    chk("to_fetch_zero", o_IRdData, 32'h0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max wait cycles for i_MemReady per transaction; legal range 1..255.
REQ-002 i_Clock  in  1  single clock; all state updates on rising edge.
REQ-003 i_Reset  in  1  asynchronous, active-low reset.
REQ-004 i_IReq  in  1  instruction-fetch request; held until o_IAck.
REQ-005 i_IAddr  in  32  fetch address; stable while i_IReq high.
REQ-006 o_IAck  out  1  one-cycle fetch completion pulse.
REQ-007 o_IRdData  out  32  fetched word; valid when o_IAck high, held until next fetch completes.
REQ-008 i_DReq  in  1  data-access request; held until o_DAck.
REQ-009 i_DWrEnable  in  1  1=store, 0=load.
REQ-010 i_DAddr  in  32  data address.
REQ-011 i_DWrData  in  32  store data.
REQ-012 o_DAck  out  1  one-cycle data completion pulse.
REQ-013 o_DRdData  out  32  load data; valid when o_DAck high, held until next load completes.
REQ-014 o_MemReq  out  1  shared memory port request.
REQ-015 o_MemWrEnable  out  1  shared port write strobe.
REQ-016 o_MemAddr  out  32  shared port address.
REQ-017 o_MemWrData  out  32  shared port write data.
REQ-018 i_MemRdData  in  32  memory read data, valid with i_MemReady.
REQ-019 i_MemReady  in  1  memory completes current access this cycle.
REQ-020 o_Busy  out  1  high while state is not IDLE.
REQ-021 o_Error  out  1  timeout flag, pulses with the ack of a timed-out transaction.

Function
REQ-022 FSM states IDLE, IBUS, DBUS; all Mem outputs registered.
REQ-023 IDLE: no request -> stay; only one requester -> grant it; both -> grant port not granted last (round robin), data wins first tie after reset.
REQ-024 On grant, latch address/write-enable/write-data into o_MemAddr/o_MemWrEnable/o_MemWrData, set o_MemReq=1, enter IBUS or DBUS next cycle; fetch grants force o_MemWrEnable=0.
REQ-025 In IBUS/DBUS, o_MemReq and latched outputs held constant until i_MemReady=1 is sampled.
REQ-026 On i_MemReady=1: next cycle o_MemReq=0, o_MemWrEnable=0, matching ack=1 for exactly one cycle, state returns to IDLE; loads/fetches capture i_MemRdData into o_DRdData/o_IRdData; stores leave o_DRdData unchanged.
REQ-027 Minimum latency: request at edge N granted, i_MemReady at N+1 -> ack high in cycle after edge N+2.
REQ-028 In the ack cycle, IDLE ignores the just-acked port's request; other port may be granted that cycle.
REQ-029 Requester deasserting request before ack: transaction still completes and acks; no abort.
REQ-030 i_MemReady while IDLE is ignored.
REQ-031 o_IAck and o_DAck never high in same cycle.

Reset
REQ-032 On i_Reset low, immediately: state IDLE, o_MemReq=0, o_MemWrEnable=0, o_MemAddr=0, o_MemWrData=0, o_IAck=0, o_DAck=0, o_IRdData=0, o_DRdData=0, o_Busy=0, o_Error=0, round-robin pointer = data-first, timeout counter=0.
REQ-033 Reset mid-transaction abandons it with no ack; first grant after release follows REQ-023.

Configuration
REQ-034 Macro MEM_ARBITER_TIMEOUT_EN defined: counter starts at 0 on entering IBUS/DBUS, increments each cycle without i_MemReady; reaching TIMEOUT terminates transaction as REQ-026 with read data captured as 0 and o_Error=1 for the ack cycle.
REQ-035 i_MemReady in the same cycle the counter reaches TIMEOUT: normal completion, o_Error=0.
REQ-036 Macro undefined: no counter, wait indefinitely, o_Error tied 0, TIMEOUT unused.

Verification
REQ-037 Fetch only: i_IReq=1, i_IAddr=0x100, i_MemReady=1 one cycle after o_MemReq, i_MemRdData=0x00000013 -> o_MemAddr=0x100, o_IAck pulse, o_IRdData=0x13.
REQ-038 Simultaneous i_IReq and i_DReq (load 0x2000) after reset -> data served first, then fetch; o_MemReq drops for one cycle between them.
REQ-039 Store i_DAddr=0x40, i_DWrData=0xDEADBEEF, i_MemReady delayed 3 cycles -> outputs stable 4 cycles, o_MemWrEnable=1, o_DAck after ready, o_DRdData unchanged.
REQ-040 Both requests held continuously for 6 transactions -> grants alternate D,I,D,I,D,I.
REQ-041 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT=4, i_MemReady never -> o_DAck and o_Error pulse together 5 cycles after grant, o_DRdData=0.
REQ-042 i_Reset low during DBUS wait -> all outputs zero immediately, no o_DAck after release.
